// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Brief    : Pipeline-side control bundle between the 4-stage pipeline and its
//            hazard/sequencing controller. Perf outputs exist only when
//            HAZARD_PERF_CNT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if;
   logic [2:0]  Rs1_ID_EX;
   logic [2:0]  Rs2_ID_EX;
   logic        RegWrite_EX_WB;
   logic [2:0]  Rd_EX_WB;
   logic        MC_op_ID_EX;
   logic        MC_done;
   logic        Branch_taken;
   logic        Halt_req;

   logic        ForwardA;
   logic        ForwardB;
   logic        MC_start;
   logic        Stall;
   logic        Bubble_EX_WB;
   logic        Flush_IF_ID;
   logic        Flush_ID_EX;
   logic        Halt_ack;
   logic        MC_err;
`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] Stall_cycles;
   logic [7:0]  Flush_count;
`endif

   // Controller side
   modport master (
      input  Rs1_ID_EX, Rs2_ID_EX, RegWrite_EX_WB, Rd_EX_WB,
             MC_op_ID_EX, MC_done, Branch_taken, Halt_req,
      output ForwardA, ForwardB, MC_start, Stall, Bubble_EX_WB,
             Flush_IF_ID, Flush_ID_EX, Halt_ack, MC_err
`ifdef HAZARD_PERF_CNT_EN
      , output Stall_cycles, Flush_count
`endif
   );

   // Pipeline side
   modport slave (
      output Rs1_ID_EX, Rs2_ID_EX, RegWrite_EX_WB, Rd_EX_WB,
             MC_op_ID_EX, MC_done, Branch_taken, Halt_req,
      input  ForwardA, ForwardB, MC_start, Stall, Bubble_EX_WB,
             Flush_IF_ID, Flush_ID_EX, Halt_ack, MC_err
`ifdef HAZARD_PERF_CNT_EN
      , input Stall_cycles, Flush_count
`endif
   );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Forwarding, branch flush, multi-cycle EX stall/timeout and halt
//            control for the 4-stage 8-bit pipeline. Optional saturating
//            performance counters enabled by HAZARD_PERF_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
   parameter int MC_TIMEOUT = 15,
   parameter int TO_W       = 4
) (
   input  logic               Clk,
   input  logic               Reset,
   pipe_hazard_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MC_WAIT = 2'd1,
      ST_HALT    = 2'd2
   } state_t;

   // Counter value in the MC_WAIT cycle that is the MC_TIMEOUT-th one
   localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(MC_TIMEOUT - 1);
   localparam logic [TO_W-1:0] c_TO_ONE  = TO_W'(1);

   state_t          state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            halt_ack_q, halt_ack_d;
   logic            mc_err_q, mc_err_d;

   logic            w_mc_start;
   logic            w_stall;
   logic            w_bubble;
   logic            w_flush;

   assign bus.ForwardA     = bus.RegWrite_EX_WB & (bus.Rd_EX_WB == bus.Rs1_ID_EX);
   assign bus.ForwardB     = bus.RegWrite_EX_WB & (bus.Rd_EX_WB == bus.Rs2_ID_EX);
   assign bus.MC_start     = w_mc_start;
   assign bus.Stall        = w_stall;
   assign bus.Bubble_EX_WB = w_bubble;
   assign bus.Flush_IF_ID  = w_flush;
   assign bus.Flush_ID_EX  = w_flush;
   assign bus.Halt_ack     = halt_ack_q;
   assign bus.MC_err       = mc_err_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mc_err_d   = mc_err_q;
      w_mc_start = 1'b0;
      w_stall    = 1'b0;
      w_bubble   = 1'b0;
      w_flush    = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (bus.MC_op_ID_EX) begin
               w_mc_start = 1'b1;
               w_stall    = 1'b1;
               w_bubble   = 1'b1;
               cnt_d      = '0;
               state_d    = ST_MC_WAIT;
            end else begin
               w_flush = bus.Branch_taken;
               if (bus.Halt_req) begin
                  state_d = ST_HALT;
               end
            end
         end

         ST_MC_WAIT: begin
            if (bus.MC_done) begin
               state_d = ST_RUN;
            end else if (cnt_q == c_TO_LAST) begin
               // Abort: release the front end but drop the EX result
               w_bubble = 1'b1;
               mc_err_d = 1'b1;
               state_d  = ST_RUN;
            end else begin
               w_stall  = 1'b1;
               w_bubble = 1'b1;
               cnt_d    = cnt_q + c_TO_ONE;
            end
         end

         ST_HALT: begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
            if (!bus.Halt_req) begin
               state_d = ST_RUN;
            end
         end

         default: begin
            state_d = ST_RUN;
         end
      endcase

      halt_ack_d = (state_d == ST_HALT);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= ST_RUN;
         cnt_q      <= '0;
         halt_ack_q <= 1'b0;
         mc_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         halt_ack_q <= halt_ack_d;
         mc_err_q   <= mc_err_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cycles_q;
   logic [7:0]  flush_count_q;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         if (w_stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_q <= stall_cycles_q + 16'd1;
         end
         if (w_flush && (flush_count_q != 8'hFF)) begin
            flush_count_q <= flush_count_q + 8'd1;
         end
      end
   end

   assign bus.Stall_cycles = stall_cycles_q;
   assign bus.Flush_count  = flush_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Self-checking bench for pipe_hazard_ctrl: directed scenarios plus
//            randomized traffic against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   localparam int MC_TIMEOUT = 15;
   localparam int TO_W       = 4;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   pipe_hazard_ctrl_if bus ();

   pipe_hazard_ctrl #(
      .MC_TIMEOUT (MC_TIMEOUT),
      .TO_W       (TO_W)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // {ForwardA, ForwardB, MC_start, Stall, Bubble, Flush_IF_ID, Flush_ID_EX, Halt_ack, MC_err}
   wire [8:0] obs = {bus.ForwardA, bus.ForwardB, bus.MC_start, bus.Stall, bus.Bubble_EX_WB,
                     bus.Flush_IF_ID, bus.Flush_ID_EX, bus.Halt_ack, bus.MC_err};

   // stim = {MC_op_ID_EX, MC_done, Branch_taken, Halt_req}
   task automatic drive(input logic [3:0] stim);
      {bus.MC_op_ID_EX, bus.MC_done, bus.Branch_taken, bus.Halt_req} = stim;
   endtask

   task automatic do_reset;
      Reset = 1'b0;
      drive(4'b0000);
      bus.RegWrite_EX_WB = 1'b0;
      bus.Rd_EX_WB  = 3'd0;
      bus.Rs1_ID_EX = 3'd1;
      bus.Rs2_ID_EX = 3'd2;
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b1;
   endtask

   task automatic test_reset;
      Reset = 1'b0;
      drive(4'b0000);
      bus.RegWrite_EX_WB = 1'b0;
      bus.Rd_EX_WB  = 3'd0;
      bus.Rs1_ID_EX = 3'd0;
      bus.Rs2_ID_EX = 3'd0;
      #1;
      n_checks++;
      if (obs !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%b exp=%b", obs, 9'b0);
      end
`ifdef HAZARD_PERF_CNT_EN
      n_checks++;
      if (bus.Stall_cycles !== 16'd0 || bus.Flush_count !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_perf got=%0d/%0d exp=0/0", bus.Stall_cycles, bus.Flush_count);
      end
`endif
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      #1;
      n_checks++;
      if (obs !== 9'b0) begin
         n_fail++;
         $display("FAIL reset_release got=%b exp=%b", obs, 9'b0);
      end
   endtask

   task automatic test_forwarding;
      logic [1:0] e;
      do_reset();
      @(negedge Clk);
      bus.RegWrite_EX_WB = 1'b1; bus.Rd_EX_WB = 3'd3; bus.Rs1_ID_EX = 3'd3; bus.Rs2_ID_EX = 3'd5;
      #1;
      n_checks++;
      if ({bus.ForwardA, bus.ForwardB} !== 2'b10) begin
         n_fail++;
         $display("FAIL fwd_vec1 got=%b exp=%b", {bus.ForwardA, bus.ForwardB}, 2'b10);
      end
      bus.RegWrite_EX_WB = 1'b0;
      #1;
      n_checks++;
      if ({bus.ForwardA, bus.ForwardB} !== 2'b00) begin
         n_fail++;
         $display("FAIL fwd_vec2 got=%b exp=%b", {bus.ForwardA, bus.ForwardB}, 2'b00);
      end
      for (int i = 0; i < 24; i++) begin
         bus.RegWrite_EX_WB = ($urandom_range(0, 3) != 0);
         bus.Rd_EX_WB  = 3'($urandom_range(0, 7));
         bus.Rs1_ID_EX = (i % 3 == 0) ? bus.Rd_EX_WB : 3'($urandom_range(0, 7));
         bus.Rs2_ID_EX = (i % 4 == 0) ? bus.Rd_EX_WB : 3'($urandom_range(0, 7));
         #1;
         e[1] = bus.RegWrite_EX_WB && (bus.Rd_EX_WB == bus.Rs1_ID_EX);
         e[0] = bus.RegWrite_EX_WB && (bus.Rd_EX_WB == bus.Rs2_ID_EX);
         n_checks++;
         if ({bus.ForwardA, bus.ForwardB} !== e) begin
            n_fail++;
            $display("FAIL fwd_rand i=%0d got=%b exp=%b", i, {bus.ForwardA, bus.ForwardB}, e);
         end
      end
      bus.RegWrite_EX_WB = 1'b0;
   endtask

   task automatic test_mc_done;
      logic [3:0] stim [5] = '{4'b1000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
      logic [8:0] expv [5] = '{9'b001110000, 9'b000110000, 9'b000110000,
                               9'b000000000, 9'b000000000};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         drive(stim[i]);
         #1;
         n_checks++;
         if (obs !== expv[i]) begin
            n_fail++;
            $display("FAIL mc_done cyc=%0d got=%b exp=%b", i, obs, expv[i]);
         end
      end
   endtask

   task automatic test_mc_timeout;
      logic [8:0] e;
      do_reset();
      for (int i = 0; i < 22; i++) begin
         @(negedge Clk);
         drive((i == 0) ? 4'b1000 : 4'b0000);
         #1;
         if (i == 0)                e = 9'b001110000;
         else if (i < MC_TIMEOUT)   e = 9'b000110000;
         else if (i == MC_TIMEOUT)  e = 9'b000010000;
         else                       e = 9'b000000001;
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL mc_timeout cyc=%0d got=%b exp=%b", i, obs, e);
         end
      end
`ifdef HAZARD_PERF_CNT_EN
      n_checks++;
      if (bus.Stall_cycles !== 16'd15 || bus.Flush_count !== 8'd0) begin
         n_fail++;
         $display("FAIL timeout_perf got=%0d/%0d exp=15/0", bus.Stall_cycles, bus.Flush_count);
      end
`endif
   endtask

   task automatic test_branch_halt;
      logic [3:0] stim [7] = '{4'b0011, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0100};
      logic [8:0] expv [7] = '{9'b000001100, 9'b000110010, 9'b000110010, 9'b000110010,
                               9'b000000000, 9'b000001100, 9'b000000000};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         @(negedge Clk);
         drive(stim[i]);
         #1;
         n_checks++;
         if (obs !== expv[i]) begin
            n_fail++;
            $display("FAIL branch_halt cyc=%0d got=%b exp=%b", i, obs, expv[i]);
         end
      end
`ifdef HAZARD_PERF_CNT_EN
      n_checks++;
      if (bus.Stall_cycles !== 16'd3 || bus.Flush_count !== 8'd2) begin
         n_fail++;
         $display("FAIL branch_perf got=%0d/%0d exp=3/2", bus.Stall_cycles, bus.Flush_count);
      end
`endif
   endtask

   task automatic test_halt_during_mc;
      logic [3:0] stim [9] = '{4'b1000, 4'b0011, 4'b0001, 4'b0101, 4'b0001,
                               4'b0001, 4'b0000, 4'b0000, 4'b0100};
      logic [8:0] expv [9] = '{9'b001110000, 9'b000110000, 9'b000110000, 9'b000000000,
                               9'b000000000, 9'b000110010, 9'b000110010, 9'b000000000,
                               9'b000000000};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         @(negedge Clk);
         drive(stim[i]);
         #1;
         n_checks++;
         if (obs !== expv[i]) begin
            n_fail++;
            $display("FAIL halt_mc cyc=%0d got=%b exp=%b", i, obs, expv[i]);
         end
      end
   endtask

   task automatic test_reset_mid_mc;
      do_reset();
      @(negedge Clk);
      drive(4'b1000);
      for (int i = 0; i < MC_TIMEOUT; i++) begin
         @(negedge Clk);
         drive(4'b0000);
      end
      @(negedge Clk);
      #1;
      n_checks++;
      if (obs !== 9'b000000001) begin
         n_fail++;
         $display("FAIL rst_mid_err_set got=%b exp=%b", obs, 9'b000000001);
      end
      @(negedge Clk);
      drive(4'b1000);
      @(negedge Clk);
      drive(4'b0000);
      #1;
      n_checks++;
      if (obs !== 9'b000110001) begin
         n_fail++;
         $display("FAIL rst_mid_wait got=%b exp=%b", obs, 9'b000110001);
      end
      #2;
      Reset = 1'b0;
      #1;
      n_checks++;
      if (obs !== 9'b0) begin
         n_fail++;
         $display("FAIL rst_mid_async got=%b exp=%b", obs, 9'b0);
      end
`ifdef HAZARD_PERF_CNT_EN
      n_checks++;
      if (bus.Stall_cycles !== 16'd0 || bus.Flush_count !== 8'd0) begin
         n_fail++;
         $display("FAIL rst_mid_perf got=%0d/%0d exp=0/0", bus.Stall_cycles, bus.Flush_count);
      end
`endif
      @(negedge Clk);
      Reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge Clk);
         #1;
         n_checks++;
         if (obs !== 9'b0) begin
            n_fail++;
            $display("FAIL rst_mid_run cyc=%0d got=%b exp=%b", i, obs, 9'b0);
         end
      end
   endtask

   task automatic test_random;
      // Model: mode 0 = running, 1 = waiting on multi-cycle unit, 2 = halted
      int   mode = 0;
      int   waited = 0;
      bit   err = 0;
      int   stall_total = 0;
      int   flush_total = 0;
      bit   halt_lvl = 0;
      bit   mc_op, done, br;
      bit   e_fa, e_fb, e_start, e_stall, e_bub, e_flush, set_err;
      int   nxt;
      logic [8:0] e;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         @(negedge Clk);
         mc_op = ($urandom_range(0, 7) == 0);
         done  = ($urandom_range(0, 5) == 0);
         br    = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 11) == 0) halt_lvl = ~halt_lvl;
         drive({mc_op, done, br, halt_lvl});
         bus.RegWrite_EX_WB = $urandom_range(0, 1);
         bus.Rd_EX_WB  = 3'($urandom_range(0, 7));
         bus.Rs1_ID_EX = 3'($urandom_range(0, 7));
         bus.Rs2_ID_EX = ($urandom_range(0, 2) == 0) ? bus.Rd_EX_WB : 3'($urandom_range(0, 7));
         #1;
         e_fa = bus.RegWrite_EX_WB && (bus.Rd_EX_WB == bus.Rs1_ID_EX);
         e_fb = bus.RegWrite_EX_WB && (bus.Rd_EX_WB == bus.Rs2_ID_EX);
         e_start = 0; e_stall = 0; e_bub = 0; e_flush = 0; set_err = 0;
         nxt = mode;
         if (mode == 0) begin
            if (mc_op) begin
               e_start = 1; e_stall = 1; e_bub = 1; nxt = 1;
            end else begin
               e_flush = br;
               if (halt_lvl) nxt = 2;
            end
         end else if (mode == 1) begin
            if (done) nxt = 0;
            else if (waited + 1 == MC_TIMEOUT) begin
               e_bub = 1; set_err = 1; nxt = 0;
            end else begin
               e_stall = 1; e_bub = 1;
            end
         end else begin
            e_stall = 1; e_bub = 1;
            if (!halt_lvl) nxt = 0;
         end
         e = {e_fa, e_fb, e_start, e_stall, e_bub, e_flush, e_flush, (mode == 2), err};
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL random cyc=%0d mode=%0d got=%b exp=%b", i, mode, obs, e);
         end
`ifdef HAZARD_PERF_CNT_EN
         n_checks++;
         if (bus.Stall_cycles !== 16'(stall_total) || bus.Flush_count !== 8'(flush_total)) begin
            n_fail++;
            $display("FAIL random_perf cyc=%0d got=%0d/%0d exp=%0d/%0d", i,
                     bus.Stall_cycles, bus.Flush_count, stall_total, flush_total);
         end
`endif
         if (e_stall && stall_total < 65535) stall_total++;
         if (e_flush && flush_total < 255) flush_total++;
         if (mode == 1 && !done) waited++;
         if (mode == 0 && nxt == 1) waited = 0;
         if (set_err) err = 1;
         mode = nxt;
      end
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_mc_done();
      test_mc_timeout();
      test_branch_halt();
      test_halt_during_mc();
      test_reset_mid_mc();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
